ps2_link: RTL and testbench
===========================

Name: ps2_link

Overview:
- PS/2 host-side link layer between the external ps2_clk/ps2_data pins and the keyboard scan-code decoder.
- Receives 11-bit device frames and delivers validated bytes as one-cycle read strobes.
- Transmits host command bytes (enable, set-LEDs, LED params) using the PS/2 request-to-send protocol.
- Drives both lines open-drain: logic 0 or high-Z only.

Parameters:
- INHIBIT_CYCLES, 1200, clk cycles ps2_clk is held low before a transmit (100 us at 12 MHz)
- EDGE_TIMEOUT, 24000, max clk cycles between ps2_clk falling edges inside a frame (2 ms)
- RTS_TIMEOUT, 180000, max clk cycles from request-to-send to first device edge (15 ms)
- FILTER_LEN, 4, consecutive equal synchronised samples needed to accept a ps2_clk level change

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_clk  inout  1  PS/2 clock, open-drain
- ps2_data  inout  1  PS/2 data, open-drain
- write  in  1  one-cycle transmit request; sampled only when busy=0
- tx_data  in  8  byte to transmit, captured in the cycle write is accepted
- read  out  1  one-cycle strobe: rx_data holds a new valid byte
- rx_data  out  8  last received byte, held until next valid byte
- busy  out  1  high whenever state is not IDLE
- rx_error  out  1  one-cycle strobe: frame rejected (parity, stop or timeout)
- tx_error  out  1  one-cycle strobe: transmit failed (no ack or timeout)

Behaviour:
- Reset (async, rst_n=0): both lines released (Z); state IDLE; read, busy, rx_error, tx_error = 0; rx_data = 0x00; all counters and shift registers cleared. This applies mid-frame: a transmit in progress is abandoned and no strobe is produced.
- Input path: 2-FF synchroniser on each line. ps2_clk additionally passes a FILTER_LEN glitch filter. A falling edge means the filtered clock goes from 1 to 0. Data is sampled from its synchroniser output in the edge cycle.
- States: IDLE, RX, TX_INHIBIT, TX_RTS, TX_BITS, TX_ACK, TX_RELEASE.
- IDLE:
  - write=1 -> capture tx_data and compute the odd-parity bit; go to TX_INHIBIT; busy=1 from the next cycle.
  - Falling edge with data=0 -> RX. write takes priority if both occur in the same cycle.
- RX:
  - Shift bits on falling edges 2..9 (LSB first); edge 10 gives parity, edge 11 gives stop.
  - After edge 11: if ones(data)+parity is odd and stop=1, load rx_data and pulse read in the same cycle. Otherwise pulse rx_error and leave rx_data unchanged.
  - Return to IDLE either way.
  - No edge for EDGE_TIMEOUT cycles -> rx_error pulse, IDLE.
- TX_INHIBIT: drive ps2_clk=0 for INHIBIT_CYCLES, then drive ps2_data=0 (start bit), release ps2_clk -> TX_RTS.
- TX_RTS: first falling edge -> drive data = bit0 -> TX_BITS. No edge within RTS_TIMEOUT -> release both lines, tx_error pulse, IDLE.
- TX_BITS:
  - On each subsequent falling edge, present the next bit: bit1..bit7, then parity. The edge after parity releases data (stop bit) -> TX_ACK.
  - The data line changes only in falling-edge cycles.
- TX_ACK: next falling edge samples data. 0 -> ack, go to TX_RELEASE. 1 -> tx_error pulse, TX_RELEASE.
- TX_RELEASE: wait until both filtered lines are 1, then IDLE. busy stays high until that point.
- Timeout in TX_BITS, TX_ACK or TX_RELEASE: EDGE_TIMEOUT elapsed -> release lines, tx_error pulse, IDLE.
- The edge-timeout counter reloads on every falling edge and on every state entry.
- write while busy=1 is ignored with no side effects.
- read, rx_error and tx_error are mutually exclusive and never last more than 1 cycle.

Test Plan:
- RX 0xAA: start 0, bits 0,1,0,1,0,1,0,1, parity 1, stop 1, edges 40 us apart -> one read pulse, rx_data=0xAA, no error strobes, busy 0 after frame.
- RX parity fault: 0x1C framed with parity 1 -> rx_error pulse, no read, rx_data still 0xAA; a following correct 0xF0 frame -> read, rx_data=0xF0.
- TX 0xED:
  - Stimulus: pulse write; pulse write again at busy=1 with 0x00; device model clocks 11 edges and acks.
  - ps2_clk=0 for 1200 cycles, then data=0 and clk released.
  - Device samples 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Second write ignored; busy falls once lines idle; tx_error 0.
- TX no-ack: same as above but device leaves data high on edge 11 -> tx_error pulse, IDLE, lines released.
- RX timeout: 5 bits then clock stops -> rx_error pulse exactly EDGE_TIMEOUT cycles after last edge; the next 0xFA frame is received correctly.
- Reset mid-TX_INHIBIT: rst_n=0 -> ps2_clk Z in the same cycle, busy 0, no strobes; after release, a write of 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_link.sv
// PS/2 host-side link layer.
// Receives 11-bit device frames and transmits host command bytes using the
// request-to-send handshake. Both pins are open-drain: driven low or released.
module ps2_link #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int EDGE_TIMEOUT   = 24000,
    parameter int RTS_TIMEOUT    = 180000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    input  logic       write,
    input  logic [7:0] tx_data,
    output logic       read,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       rx_error,
    output logic       tx_error
);

    localparam int TMAX_A = (INHIBIT_CYCLES > EDGE_TIMEOUT) ? INHIBIT_CYCLES : EDGE_TIMEOUT;
    localparam int TMAX   = (TMAX_A > RTS_TIMEOUT) ? TMAX_A : RTS_TIMEOUT;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int FW     = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RX         = 3'd1,
        ST_TX_INHIBIT = 3'd2,
        ST_TX_RTS     = 3'd3,
        ST_TX_BITS    = 3'd4,
        ST_TX_ACK     = 3'd5,
        ST_TX_RELEASE = 3'd6
    } state_t;

    // Odd parity bit: makes the total count of ones across data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

    state_t          state_r;
    logic [1:0]      clk_sync_r;
    logic [1:0]      data_sync_r;
    logic            clk_filt_r;
    logic            clk_filt_prev_r;
    logic [FW-1:0]   filt_cnt_r;
    logic [TW-1:0]   timer_r;
    logic [3:0]      bit_cnt_r;
    logic [7:0]      rx_shift_r;
    logic            rx_par_r;
    logic [8:0]      tx_shift_r;
    logic            clk_oe_r;
    logic            data_oe_r;
    logic            read_r;
    logic            rx_error_r;
    logic            tx_error_r;
    logic            busy_r;
    logic [7:0]      rx_data_r;
    logic            fall_s;
    logic            data_s;

    // Open-drain pin drivers: pull low or release.
    assign ps2_clk  = clk_oe_r  ? 1'b0 : 1'bz;
    assign ps2_data = data_oe_r ? 1'b0 : 1'bz;

    assign fall_s   = clk_filt_prev_r & ~clk_filt_r;
    assign data_s   = data_sync_r[1];

    assign read     = read_r;
    assign rx_data  = rx_data_r;
    assign busy     = busy_r;
    assign rx_error = rx_error_r;
    assign tx_error = tx_error_r;

    // Two-flop synchronisers plus a run-length glitch filter on the clock line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_r      <= 2'b11;
            data_sync_r     <= 2'b11;
            clk_filt_r      <= 1'b1;
            clk_filt_prev_r <= 1'b1;
            filt_cnt_r      <= '0;
        end else begin
            clk_sync_r      <= {clk_sync_r[0], ps2_clk};
            data_sync_r     <= {data_sync_r[0], ps2_data};
            clk_filt_prev_r <= clk_filt_r;
            if (clk_sync_r[1] == clk_filt_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
                clk_filt_r <= clk_sync_r[1];
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FW'(1);
            end
        end
    end

    // Link state machine: receive framing, request-to-send transmit and timeouts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            timer_r    <= '0;
            bit_cnt_r  <= 4'd0;
            rx_shift_r <= 8'h00;
            rx_par_r   <= 1'b0;
            tx_shift_r <= 9'h000;
            clk_oe_r   <= 1'b0;
            data_oe_r  <= 1'b0;
            read_r     <= 1'b0;
            rx_error_r <= 1'b0;
            tx_error_r <= 1'b0;
            busy_r     <= 1'b0;
            rx_data_r  <= 8'h00;
        end else begin
            read_r     <= 1'b0;
            rx_error_r <= 1'b0;
            tx_error_r <= 1'b0;
            timer_r    <= timer_r + TW'(1);
            case (state_r)
                ST_IDLE: begin
                    timer_r <= '0;
                    if (write) begin
                        tx_shift_r <= {odd_parity(tx_data), tx_data};
                        clk_oe_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_TX_INHIBIT;
                    end else if (fall_s && !data_s) begin
                        bit_cnt_r <= 4'd1;
                        busy_r    <= 1'b1;
                        state_r   <= ST_RX;
                    end
                end
                ST_RX: begin
                    if (fall_s) begin
                        timer_r   <= '0;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r <= 4'd8) begin
                            rx_shift_r <= {data_s, rx_shift_r[7:1]};
                        end else if (bit_cnt_r == 4'd9) begin
                            rx_par_r <= data_s;
                        end else begin
                            if ((^{rx_shift_r, rx_par_r}) && data_s) begin
                                rx_data_r <= rx_shift_r;
                                read_r    <= 1'b1;
                            end else begin
                                rx_error_r <= 1'b1;
                            end
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end else if (timer_r == TW'(EDGE_TIMEOUT - 1)) begin
                        rx_error_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_TX_INHIBIT: begin
                    // Our own low clock is ignored here; only the hold time matters.
                    if (timer_r == TW'(INHIBIT_CYCLES - 1)) begin
                        clk_oe_r  <= 1'b0;
                        data_oe_r <= 1'b1;
                        timer_r   <= '0;
                        state_r   <= ST_TX_RTS;
                    end
                end
                ST_TX_RTS: begin
                    if (fall_s) begin
                        data_oe_r  <= ~tx_shift_r[0];
                        tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                        bit_cnt_r  <= 4'd0;
                        timer_r    <= '0;
                        state_r    <= ST_TX_BITS;
                    end else if (timer_r == TW'(RTS_TIMEOUT - 1)) begin
                        clk_oe_r   <= 1'b0;
                        data_oe_r  <= 1'b0;
                        tx_error_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_TX_BITS: begin
                    if (fall_s) begin
                        timer_r <= '0;
                        if (bit_cnt_r == 4'd8) begin
                            // Parity already out: release data as the stop bit.
                            data_oe_r <= 1'b0;
                            state_r   <= ST_TX_ACK;
                        end else begin
                            data_oe_r  <= ~tx_shift_r[0];
                            tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                            bit_cnt_r  <= bit_cnt_r + 4'd1;
                        end
                    end else if (timer_r == TW'(EDGE_TIMEOUT - 1)) begin
                        clk_oe_r   <= 1'b0;
                        data_oe_r  <= 1'b0;
                        tx_error_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_TX_ACK: begin
                    if (fall_s) begin
                        timer_r    <= '0;
                        tx_error_r <= data_s;
                        state_r    <= ST_TX_RELEASE;
                    end else if (timer_r == TW'(EDGE_TIMEOUT - 1)) begin
                        clk_oe_r   <= 1'b0;
                        data_oe_r  <= 1'b0;
                        tx_error_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_TX_RELEASE: begin
                    if (clk_filt_r && data_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (timer_r == TW'(EDGE_TIMEOUT - 1)) begin
                        clk_oe_r   <= 1'b0;
                        data_oe_r  <= 1'b0;
                        tx_error_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_link.sv
// Directed testbench for ps2_link with a behavioural PS/2 device on the pins.
module tb_ps2_link;

    localparam int INH       = 1200;
    localparam int ET        = 24000;
    localparam int RTS       = 180000;
    localparam int FL        = 4;
    localparam int H         = 240;        // half bit period: edges 40 us apart at 12 MHz
    localparam int EDGE_LAT  = 2 + FL + 1; // pin fall -> edge registered: 2 sync + filter + edge reg

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       read;
    logic [7:0] rx_data;
    logic       busy;
    logic       rx_error;
    logic       tx_error;
    wire        ps2_clk_w;
    wire        ps2_data_w;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    pullup (ps2_clk_w);
    pullup (ps2_data_w);
    assign ps2_clk_w  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data_w = dev_data_low ? 1'b0 : 1'bz;

    ps2_link #(
        .INHIBIT_CYCLES(INH),
        .EDGE_TIMEOUT  (ET),
        .RTS_TIMEOUT   (RTS),
        .FILTER_LEN    (FL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ps2_clk (ps2_clk_w),
        .ps2_data(ps2_data_w),
        .write   (write),
        .tx_data (tx_data),
        .read    (read),
        .rx_data (rx_data),
        .busy    (busy),
        .rx_error(rx_error),
        .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int read_cnt = 0;
    int rxerr_cnt = 0;
    int txerr_cnt = 0;
    int rxerr_cyc = 0;
    int strobe_viol = 0;
    int last_fall_cyc = 0;
    logic read_prev = 1'b0;
    logic rxe_prev = 1'b0;
    logic txe_prev = 1'b0;

    // Cycle counter advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts pulses and flags overlap or pulses longer than one cycle.
    always @(negedge clk) begin
        if (read) read_cnt = read_cnt + 1;
        if (rx_error) begin
            rxerr_cnt = rxerr_cnt + 1;
            rxerr_cyc = cyc;
        end
        if (tx_error) txerr_cnt = txerr_cnt + 1;
        if ((int'(read) + int'(rx_error) + int'(tx_error)) > 1) strobe_viol = strobe_viol + 1;
        if ((read && read_prev) || (rx_error && rxe_prev) || (tx_error && txe_prev))
            strobe_viol = strobe_viol + 1;
        read_prev = read;
        rxe_prev  = rx_error;
        txe_prev  = tx_error;
    end

    task automatic dev_edge(input logic bitv);
        dev_data_low = ~bitv;
        repeat (H) @(negedge clk);
        dev_clk_low   = 1'b1;
        last_fall_cyc = cyc;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s, input int nedges);
        logic [10:0] f;
        f = {s, p, b, 1'b0};
        for (int e = 0; e < nedges; e++) dev_edge(f[e]);
        dev_data_low = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({read, rx_error, tx_error} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {read, rx_error, tx_error}); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if ({ps2_clk_w, ps2_data_w} !== 2'b11) begin errors++; $display("FAIL reset_lines got %b want 11", {ps2_clk_w, ps2_data_w}); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_rx_aa;
        int r0, e0, t0;
        r0 = read_cnt; e0 = rxerr_cnt; t0 = txerr_cnt;
        send_frame(8'hAA, 1'b1, 1'b1, 11);
        checks++; if (read_cnt - r0 !== 1) begin errors++; $display("FAIL rx_aa_read got %0d want 1", read_cnt - r0); end
        checks++; if (rx_data !== 8'hAA) begin errors++; $display("FAIL rx_aa_data got %h want aa", rx_data); end
        checks++; if ((rxerr_cnt - e0) + (txerr_cnt - t0) !== 0) begin errors++; $display("FAIL rx_aa_err got %0d want 0", (rxerr_cnt - e0) + (txerr_cnt - t0)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rx_aa_busy got %b want 0", busy); end
    endtask

    task automatic test_rx_parity;
        int r0, e0;
        r0 = read_cnt; e0 = rxerr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        checks++; if (rxerr_cnt - e0 !== 1) begin errors++; $display("FAIL par_rx_error got %0d want 1", rxerr_cnt - e0); end
        checks++; if (read_cnt - r0 !== 0) begin errors++; $display("FAIL par_read got %0d want 0", read_cnt - r0); end
        checks++; if (rx_data !== 8'hAA) begin errors++; $display("FAIL par_hold got %h want aa", rx_data); end
        r0 = read_cnt;
        send_frame(8'hF0, 1'b1, 1'b1, 11);
        checks++; if (read_cnt - r0 !== 1) begin errors++; $display("FAIL par_f0_read got %0d want 1", read_cnt - r0); end
        checks++; if (rx_data !== 8'hF0) begin errors++; $display("FAIL par_f0_data got %h want f0", rx_data); end
    endtask

    task automatic test_tx(input logic [7:0] b, input logic exp_par, input logic ack,
                           input logic second_write, input int exp_err);
        int c_acc, c_rel, t0, r0, n;
        logic [9:0] got;
        t0 = txerr_cnt; r0 = read_cnt;
        @(negedge clk);
        tx_data = b; write = 1'b1;
        @(negedge clk);
        write = 1'b0; tx_data = 8'h00;
        c_acc = cyc;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tx_%h_busy_rise got %b want 1", b, busy); end
        if (second_write) begin
            write = 1'b1;
            @(negedge clk);
            write = 1'b0;
        end
        n = 0;
        while (ps2_clk_w !== 1'b1 && n < INH + 100) begin
            @(negedge clk);
            n++;
        end
        c_rel = cyc;
        checks++; if (c_rel - c_acc !== INH) begin errors++; $display("FAIL tx_%h_inhibit got %0d want %0d", b, c_rel - c_acc, INH); end
        checks++; if (ps2_data_w !== 1'b0) begin errors++; $display("FAIL tx_%h_start got %b want 0", b, ps2_data_w); end
        repeat (50) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
            if (e <= 10) got[e-1] = ps2_data_w;
        end
        dev_data_low = 1'b0;
        checks++; if (got !== {1'b1, exp_par, b}) begin errors++; $display("FAIL tx_%h_bits got %b want %b", b, got, {1'b1, exp_par, b}); end
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tx_%h_busy_fall got %b want 0", b, busy); end
        checks++; if (txerr_cnt - t0 !== exp_err) begin errors++; $display("FAIL tx_%h_tx_error got %0d want %0d", b, txerr_cnt - t0, exp_err); end
        repeat (100) @(negedge clk);
        checks++; if ({busy, ps2_clk_w, ps2_data_w} !== 3'b011) begin errors++; $display("FAIL tx_%h_idle got %b want 011", b, {busy, ps2_clk_w, ps2_data_w}); end
        checks++; if (read_cnt - r0 !== 0) begin errors++; $display("FAIL tx_%h_no_read got %0d want 0", b, read_cnt - r0); end
    endtask

    task automatic test_rx_timeout;
        int r0, e0, n;
        r0 = read_cnt; e0 = rxerr_cnt;
        for (int e = 0; e < 5; e++) dev_edge(1'b0);
        dev_data_low = 1'b0;
        n = 0;
        while (rxerr_cnt == e0 && n < ET + 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rxerr_cnt - e0 !== 1) begin errors++; $display("FAIL rx_to_pulse got %0d want 1", rxerr_cnt - e0); end
        checks++; if (rxerr_cyc - last_fall_cyc !== ET + EDGE_LAT) begin errors++; $display("FAIL rx_to_delay got %0d want %0d", rxerr_cyc - last_fall_cyc, ET + EDGE_LAT); end
        checks++; if (read_cnt - r0 !== 0) begin errors++; $display("FAIL rx_to_read got %0d want 0", read_cnt - r0); end
        repeat (20) @(negedge clk);
        send_frame(8'hFA, 1'b1, 1'b1, 11);
        checks++; if (read_cnt - r0 !== 1) begin errors++; $display("FAIL rx_fa_read got %0d want 1", read_cnt - r0); end
        checks++; if (rx_data !== 8'hFA) begin errors++; $display("FAIL rx_fa_data got %h want fa", rx_data); end
    endtask

    task automatic test_reset_mid_tx;
        int r0, e0, t0;
        @(negedge clk);
        tx_data = 8'h55; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        repeat (100) @(negedge clk);
        checks++; if (ps2_clk_w !== 1'b0) begin errors++; $display("FAIL rst_mid_inhibit got %b want 0", ps2_clk_w); end
        r0 = read_cnt; e0 = rxerr_cnt; t0 = txerr_cnt;
        rst_n = 1'b0;
        #1;
        checks++; if ({ps2_clk_w, ps2_data_w, busy} !== 3'b110) begin errors++; $display("FAIL rst_mid_release got %b want 110", {ps2_clk_w, ps2_data_w, busy}); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if ((read_cnt - r0) + (rxerr_cnt - e0) + (txerr_cnt - t0) !== 0) begin errors++; $display("FAIL rst_mid_strobes got %0d want 0", (read_cnt - r0) + (rxerr_cnt - e0) + (txerr_cnt - t0)); end
        test_tx(8'hF4, 1'b0, 1'b1, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_rx_aa();
        test_rx_parity();
        test_tx(8'hED, 1'b1, 1'b1, 1'b1, 0);
        test_tx(8'hED, 1'b1, 1'b0, 1'b0, 1);
        test_rx_timeout();
        test_reset_mid_tx();
        checks++; if (strobe_viol !== 0) begin errors++; $display("FAIL strobe_shape got %0d want 0", strobe_viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
